// File: rtl/rv_wb_arbiter.sv
// rv_wb_arbiter: shares the register-file write port between pipeline write-back and a buffered long-latency unit.
// Define RV_WB_BYPASS_EN to let a long-latency result skip an empty FIFO into an idle write slot.
module rv_wb_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_we,
    input  logic [4:0]  i_wb_rd,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_stall,
    input  logic        i_lu_valid,
    input  logic [4:0]  i_lu_rd,
    input  logic [31:0] i_lu_data,
    output logic        o_lu_ready,
    output logic        o_rf_we,
    output logic [4:0]  o_rf_rd,
    output logic [31:0] o_rf_data,
    output logic [31:0] o_pend_mask
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    r_fifo_rd   [DEPTH];
    logic [31:0]   r_fifo_data [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [3:0]    r_wait;
    logic [31:0]   r_pend;
    logic          r_rf_we;
    logic [4:0]    r_rf_rd;
    logic [31:0]   r_rf_data;

    logic          w_wb_req;
    logic          w_empty;
    logic          w_lu_push;
    logic          w_force;
    logic          w_pop;
    logic          w_bypass;
    logic          w_fifo_wr;
    logic [4:0]    w_head_rd;
    logic [31:0]   w_head_data;
    logic [31:0]   w_set;
    logic [31:0]   w_clr;

    assign w_wb_req    = i_wb_we && (i_wb_rd != 5'd0);
    assign w_empty     = (r_count == '0);
    assign o_lu_ready  = (r_count != CW'(DEPTH));
    assign w_lu_push   = i_lu_valid && o_lu_ready;
    assign w_force     = !w_empty && (r_wait == 4'(MAX_WAIT));
    assign w_pop       = w_force || (!w_wb_req && !w_empty);
    assign o_wb_stall  = w_force && w_wb_req;
    assign w_head_rd   = r_fifo_rd[r_rptr];
    assign w_head_data = r_fifo_data[r_rptr];

`ifdef RV_WB_BYPASS_EN
    assign w_bypass = w_empty && i_lu_valid && (i_lu_rd != 5'd0) && !w_wb_req;
`else
    assign w_bypass = 1'b0;
`endif

    // x0 results are accepted but never stored
    assign w_fifo_wr = w_lu_push && (i_lu_rd != 5'd0) && !w_bypass;
    assign w_set     = w_fifo_wr ? (32'd1 << i_lu_rd) : 32'd0;
    assign w_clr     = w_pop ? (32'd1 << w_head_rd) : 32'd0;

    always_ff @(posedge i_clk) begin
        if (w_fifo_wr) begin
            r_fifo_rd[r_wptr]   <= i_lu_rd;
            r_fifo_data[r_wptr] <= i_lu_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_wait    <= 4'd0;
            r_pend    <= 32'd0;
            r_rf_we   <= 1'b0;
            r_rf_rd   <= 5'd0;
            r_rf_data <= 32'd0;
        end else begin
            r_wptr  <= w_fifo_wr ? r_wptr + AW'(1) : r_wptr;
            r_rptr  <= w_pop ? r_rptr + AW'(1) : r_rptr;
            r_count <= r_count + CW'(w_fifo_wr) - CW'(w_pop);
            // only pipeline grants over a waiting head count toward starvation
            r_wait  <= (w_wb_req && !w_force && !w_empty) ? r_wait + 4'd1 : 4'd0;
            r_pend  <= (r_pend | w_set) & ~w_clr;
            if (w_pop) begin
                r_rf_we   <= 1'b1;
                r_rf_rd   <= w_head_rd;
                r_rf_data <= w_head_data;
            end else if (w_wb_req) begin
                r_rf_we   <= 1'b1;
                r_rf_rd   <= i_wb_rd;
                r_rf_data <= i_wb_data;
            end else if (w_bypass) begin
                r_rf_we   <= 1'b1;
                r_rf_rd   <= i_lu_rd;
                r_rf_data <= i_lu_data;
            end else begin
                r_rf_we   <= 1'b0;
            end
        end
    end

    assign o_rf_we     = r_rf_we;
    assign o_rf_rd     = r_rf_rd;
    assign o_rf_data   = r_rf_data;
    assign o_pend_mask = r_pend;
endmodule

// File: tb/tb_rv_wb_arbiter.sv
// tb_rv_wb_arbiter: directed checks of rv_wb_arbiter with DEPTH=2, MAX_WAIT=4.
module tb_rv_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_stall;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic [31:0] pend_mask;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    rv_wb_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_wb_we(wb_we),
        .i_wb_rd(wb_rd),
        .i_wb_data(wb_data),
        .o_wb_stall(wb_stall),
        .i_lu_valid(lu_valid),
        .i_lu_rd(lu_rd),
        .i_lu_data(lu_data),
        .o_lu_ready(lu_ready),
        .o_rf_we(rf_we),
        .o_rf_rd(rf_rd),
        .o_rf_data(rf_data),
        .o_pend_mask(pend_mask)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_rf(input string tag, input logic [4:0] rd, input logic [31:0] d);
        check({tag, "_we"}, 32'(rf_we), 32'd1);
        check({tag, "_rd"}, 32'(rf_rd), 32'(rd));
        check({tag, "_data"}, rf_data, d);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] d,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        wb_we    = we;
        wb_rd    = rd;
        wb_data  = d;
        lu_valid = lv;
        lu_rd    = lrd;
        lu_data  = ld;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        tick;
        tick;
        check("rst_we", 32'(rf_we), 0);
        check("rst_rd", 32'(rf_rd), 0);
        check("rst_data", rf_data, 0);
        check("rst_mask", pend_mask, 0);
        check("rst_ready", 32'(lu_ready), 1);
        check("rst_stall", 32'(wb_stall), 0);
        rst = 1'b0;

        drive(1, 5, 32'h1234, 0, 0, 0);
        tick;
        check_rf("pipe", 5, 32'h1234);
        check("pipe_mask", pend_mask, 0);
        drive(1, 0, 32'hffff, 0, 0, 0);
        tick;
        check("pipe_x0_we", 32'(rf_we), 0);

        drive(0, 0, 0, 1, 7, 32'hdeadbeef);
        #1 check("drain_ready", 32'(lu_ready), 1);
        tick;
        drive(0, 0, 0, 0, 0, 0);
`ifdef RV_WB_BYPASS_EN
        check_rf("bypass", 7, 32'hdeadbeef);
        check("bypass_mask", pend_mask, 0);
        tick;
        check("bypass_after_we", 32'(rf_we), 0);
        check("bypass_after_mask", pend_mask, 0);
`else
        check("drain_mask_set", pend_mask, 32'h80);
        check("drain_wait_we", 32'(rf_we), 0);
        tick;
        check_rf("drain", 7, 32'hdeadbeef);
        check("drain_mask_clr", pend_mask, 0);
`endif
        tick;
        check("drain_idle_we", 32'(rf_we), 0);

        drive(1, 1, 32'h100, 1, 9, 32'h99);
        tick;
        check_rf("starve_a", 1, 32'h100);
        check("starve_mask", pend_mask, 32'h200);
        for (int k = 2; k <= 5; k++) begin
            drive(1, 5'(k), 32'(k * 256), 0, 0, 0);
            #1 check("starve_nostall", 32'(wb_stall), 0);
            tick;
            check_rf("starve_pipe", 5'(k), 32'(k * 256));
        end
        drive(1, 6, 32'h600, 0, 0, 0);
        #1 check("starve_stall", 32'(wb_stall), 1);
        tick;
        check_rf("starve_force", 9, 32'h99);
        check("starve_mask_clr", pend_mask, 0);
        #1 check("starve_stall_once", 32'(wb_stall), 0);
        tick;
        check_rf("starve_held", 6, 32'h600);
        drive(0, 0, 0, 0, 0, 0);
        tick;

        drive(1, 1, 32'h11, 1, 10, 32'ha0);
        #1 check("full_ready1", 32'(lu_ready), 1);
        tick;
        check_rf("full_p1", 1, 32'h11);
        drive(1, 2, 32'h12, 1, 11, 32'hb0);
        #1 check("full_ready2", 32'(lu_ready), 1);
        tick;
        check_rf("full_p2", 2, 32'h12);
        check("full_mask2", pend_mask, 32'h0c00);
        for (int k = 3; k <= 5; k++) begin
            drive(1, 5'(k), 32'(32'h10 + k), 1, 12, 32'hc0);
            #1 check("full_notready", 32'(lu_ready), 0);
            tick;
            check_rf("full_pk", 5'(k), 32'(32'h10 + k));
        end
        drive(1, 6, 32'h16, 1, 12, 32'hc0);
        #1 check("full_stall", 32'(wb_stall), 1);
        check("full_ready_force", 32'(lu_ready), 0);
        tick;
        check_rf("full_a", 10, 32'ha0);
        #1 check("full_stall_clr", 32'(wb_stall), 0);
        check("full_ready_again", 32'(lu_ready), 1);
        tick;
        check_rf("full_p6", 6, 32'h16);
        check("full_mask7", pend_mask, 32'h1800);
        drive(0, 0, 0, 0, 0, 0);
        tick;
        check_rf("full_b", 11, 32'hb0);
        tick;
        check_rf("full_c", 12, 32'hc0);
        check("full_mask_end", pend_mask, 0);
        tick;
        check("full_idle_we", 32'(rf_we), 0);

        drive(1, 1, 32'h21, 1, 16, 32'h1000);
        tick;
        check_rf("pp_seed", 1, 32'h21);
        for (int i = 1; i <= 10; i++) begin
            drive(0, 0, 0, 1, 5'(16 + i), 32'(32'h1000 + i));
            #1 check("pp_ready", 32'(lu_ready), 1);
            tick;
            check_rf("pp", 5'(16 + i - 1), 32'(32'h1000 + i - 1));
            check("pp_mask", pend_mask, 32'd1 << (16 + i));
        end
        drive(0, 0, 0, 0, 0, 0);
        tick;
        check_rf("pp_last", 26, 32'h100a);
        check("pp_mask_end", pend_mask, 0);
        tick;
        check("pp_idle_we", 32'(rf_we), 0);

        drive(1, 1, 32'h31, 1, 20, 32'h200);
        tick;
        drive(1, 2, 32'h32, 1, 21, 32'h210);
        tick;
        check("mrst_mask_before", pend_mask, 32'h0030_0000);
        #1 rst = 1'b1;
        #1;
        check("mrst_we", 32'(rf_we), 0);
        check("mrst_rd", 32'(rf_rd), 0);
        check("mrst_data", rf_data, 0);
        check("mrst_mask", pend_mask, 0);
        check("mrst_ready", 32'(lu_ready), 1);
        check("mrst_stall", 32'(wb_stall), 0);
        drive(0, 0, 0, 0, 0, 0);
        tick;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("mrst_no_write", 32'(rf_we), 0);
            check("mrst_mask_after", pend_mask, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/rv_wb_arbiter.md
# rv_wb_arbiter

Arbiter for the single register-file write port. It shares that port between the in-order pipeline write-back result and a long-latency unit, such as a multiplier/divider or a slow load path, that returns results asynchronously to the pipeline. Long-latency results are buffered in a small FIFO and written in idle write-back slots. A starvation counter forces a one-cycle pipeline stall when a buffered result waits too long. The block sits between the write-back stage and the register file, and it exports a pending-destination mask for the issue scoreboard.

## Interface

Parameters:
- DEPTH, 2: long-latency result FIFO entries; power of two, 2..8.
- MAX_WAIT, 4: cycles a FIFO head may wait before a forced grant; 1..15.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_wb_we  in  1  pipeline write-back request.
- i_wb_rd  in  5  pipeline destination register.
- i_wb_data  in  32  pipeline result.
- o_wb_stall  out  1  pipeline must hold its write-back inputs this cycle; combinational.
- i_lu_valid  in  1  long-latency result valid.
- i_lu_rd  in  5  long-latency destination register.
- i_lu_data  in  32  long-latency result.
- o_lu_ready  out  1  FIFO can accept; derived from registered state only.
- o_rf_we  out  1  register-file write enable; registered.
- o_rf_rd  out  5  register-file write address; registered.
- o_rf_data  out  32  register-file write data; registered.
- o_pend_mask  out  32  bit n set means a result for xn has been accepted but not yet driven on o_rf_*; bit 0 is always 0.

## Operation

- Request qualification:
  - Pipeline request: wb_req = i_wb_we && i_wb_rd != 0.
  - Long-latency push: lu_push = i_lu_valid && o_lu_ready.
  - A push with i_lu_rd == 0 is accepted and discarded (no FIFO entry).
- Grant, evaluated each cycle, first match wins:
  1. FIFO non-empty and r_wait == MAX_WAIT: grant the FIFO head. o_wb_stall = wb_req. r_wait clears.
  2. wb_req: grant the pipeline. o_wb_stall = 0. If the FIFO is non-empty, r_wait increments.
  3. FIFO non-empty: grant the FIFO head. r_wait clears.
  4. Nothing: o_rf_we <= 0.
- The granted source loads o_rf_we/rd/data at the clock edge. A stalled pipeline request is re-presented next cycle and is not lost.
- FIFO behaviour:
  - Circular buffer with a count of width clog2(DEPTH)+1; pointers wrap modulo DEPTH.
  - Push and pop in the same cycle are both performed and the count is unchanged.
  - o_lu_ready = (count != DEPTH). A push is never accepted while full, even if a pop occurs in the same cycle.
- o_pend_mask:
  - Bit set at the edge a nonzero rd is accepted.
  - Bit cleared at the edge that rd is loaded into o_rf_*.
  - Upstream guarantees at most one outstanding long-latency result per rd, and no pipeline write to a pending rd (no WAW conflicts). Behaviour is undefined if this is violated.
- Reset, applied asynchronously:
  - o_rf_we=0, o_rf_rd=0, o_rf_data=0, o_pend_mask=0, r_wait=0, FIFO empty.
  - Therefore o_lu_ready=1 and o_wb_stall=0.
  - Reset mid-operation discards all buffered results without writing them.

## Timing

- Pipeline request: request in cycle N, o_rf_we=1 in cycle N+1, provided it is not stalled.
- Long-latency result, FIFO path: accepted in cycle N, pushed at edge N, earliest write on o_rf_* in cycle N+2.
- Maximum FIFO-head wait: MAX_WAIT pipeline-granted cycles. The forced grant occurs in cycle MAX_WAIT+1 after the head becomes eligible.
- o_wb_stall is never high for two consecutive cycles, because r_wait clears on each forced grant.
- o_lu_ready deasserts in the cycle after the push that fills the FIFO.

## Configuration

- RV_WB_BYPASS_EN defined:
  - Condition: FIFO empty, i_lu_valid, i_lu_rd != 0, and no wb_req.
  - Effect: the result loads o_rf_* directly at the accepting edge, with no push and latency 1. The o_pend_mask bit is never set for it.
- RV_WB_BYPASS_EN undefined: every long-latency result goes through the FIFO; minimum latency is 2.

## Test plan

- Reset: assert i_reset mid-burst with 2 FIFO entries.
  - Outputs go 0 immediately, o_lu_ready=1, o_pend_mask=0.
  - No buffered write appears after release.
- Pipeline only: i_wb_we=1, rd=5, data=0x1234 in cycle N.
  - Cycle N+1: o_rf_we=1, rd=5, data=0x1234.
  - Same stimulus with rd=0: o_rf_we stays 0.
- Idle-slot drain: LU result rd=7, data=0xDEADBEEF with the pipeline idle.
  - o_pend_mask[7]=1 for 1 cycle, then o_rf_* carries rd 7 two cycles after acceptance, and the mask bit clears.
  - With RV_WB_BYPASS_EN: written after 1 cycle, mask[7] never set.
- Starvation (MAX_WAIT=4): pipeline writes every cycle with one LU entry rd=9 buffered.
  - Exactly 4 pipeline writes, then o_wb_stall=1 for one cycle and rd 9 is written.
  - The held pipeline write follows next cycle unchanged.
- Full/back-pressure (DEPTH=2): 3 back-to-back LU results while the pipeline writes continuously.
  - o_lu_ready=0 after the second push, and the third result is held.
  - All three are written, in order, with no loss or duplication.
- Simultaneous push/pop with count=1: count stays 1, the oldest entry is written, and the pointers wrap correctly across 10 iterations.
